// File: rtl/onehot_op_decoder.sv
// Registered one-hot operation-select decoder with valid/ready intake, a programmable hold window and a done pulse.
// Optional build macro ONEHOT_RETRIGGER_EN lets a new select pre-empt the current hold window.
module onehot_op_decoder #(
    parameter int SEL_W    = 3,
    parameter int OUT_W    = 8,
    parameter int HOLD_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel,
    output logic             sel_ready,
    output logic [OUT_W-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYC - 1);

`ifdef ONEHOT_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             in_range;
    logic             accept;

    assign in_range  = (32'(sel) < 32'(OUT_W));
    assign sel_ready = en && !rst &&
                       ((state_q == ST_IDLE) || (RETRIG && (state_q == ST_ACTIVE)));
    assign accept    = sel_valid && sel_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // With en low everything holds, so a pending err or DONE is simply deferred.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (en) begin
            err_d = accept && !in_range;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept && in_range) begin
                        sel_d   = sel;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (accept && in_range) begin
                        sel_d = sel;
                        cnt_d = CNT_LOAD;
                    end else if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = en && (state_q == ST_DONE);
    assign err  = en && err_q;

    // Each bit is a single equality compare against the registered select, so at most one is ever high.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
            assign y[gi] = en && (state_q == ST_ACTIVE) && (32'(sel_q) == 32'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_onehot_op_decoder.sv
// Bench for onehot_op_decoder: two instances (8-way/hold 1 and 6-way/hold 4) checked every cycle against a behavioural model.
module tb_onehot_op_decoder;

`ifdef ONEHOT_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    localparam int OUT_A = 8, HOLD_A = 1;
    localparam int OUT_B = 6, HOLD_B = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, vld_a, en_b, vld_b;
    logic [2:0] sel_a, sel_b;
    logic       rdy_a, busy_a, done_a, err_a;
    logic       rdy_b, busy_b, done_b, err_b;
    logic [7:0] y_a;
    logic [5:0] y_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    onehot_op_decoder #(.SEL_W(3), .OUT_W(OUT_A), .HOLD_CYC(HOLD_A)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .sel_valid(vld_a), .sel(sel_a),
        .sel_ready(rdy_a), .y(y_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    onehot_op_decoder #(.SEL_W(3), .OUT_W(OUT_B), .HOLD_CYC(HOLD_B)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .sel_valid(vld_b), .sel(sel_b),
        .sel_ready(rdy_b), .y(y_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // rem: output cycles left in the hold window; done_owed/err_owed: pulses still to be shown.
    typedef struct {
        int rem;
        int cur;
        bit done_owed;
        bit err_owed;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t m_reset();
        mdl_t m;
        m.rem = 0; m.cur = 0; m.done_owed = 1'b0; m.err_owed = 1'b0;
        return m;
    endfunction

    function automatic bit m_ready(mdl_t m, bit en);
        return en && ((m.rem == 0 && !m.done_owed) || (RETRIG && m.rem > 0));
    endfunction

    function automatic logic [31:0] m_y(mdl_t m, bit en);
        return (en && m.rem > 0) ? (32'd1 << m.cur) : 32'd0;
    endfunction

    task automatic m_step(inout mdl_t m, input bit en, input bit vld, input int s,
                          input int out_w, input int hold, input string name);
        bit acc;
        if (!en) return;
        acc = vld && m_ready(m, en);
        if (acc) $display("txn %s sel=%0d %s", name, s, (s < out_w) ? "decode" : "out-of-range");
        m.err_owed = 1'b0;
        if (m.done_owed) begin
            m.done_owed = 1'b0;
        end else if (m.rem > 0) begin
            if (acc && s < out_w) begin
                m.cur = s;
                m.rem = hold;
            end else begin
                if (acc) m.err_owed = 1'b1;
                m.rem--;
                if (m.rem == 0) m.done_owed = 1'b1;
            end
        end else if (acc) begin
            if (s < out_w) begin
                m.cur = s;
                m.rem = hold;
            end else begin
                m.err_owed = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("y_a",      32'(y_a),            m_y(ma, en_a));
        chk("done_a",   32'(done_a),         32'(en_a && ma.done_owed));
        chk("err_a",    32'(err_a),          32'(en_a && ma.err_owed));
        chk("busy_a",   32'(busy_a),         32'(ma.rem > 0 || ma.done_owed));
        chk("ready_a",  32'(rdy_a),          32'(m_ready(ma, en_a)));
        chk("onehot_a", 32'($countones(y_a) <= 1), 32'd1);
        chk("y_b",      32'(y_b),            m_y(mb, en_b));
        chk("done_b",   32'(done_b),         32'(en_b && mb.done_owed));
        chk("err_b",    32'(err_b),          32'(en_b && mb.err_owed));
        chk("busy_b",   32'(busy_b),         32'(mb.rem > 0 || mb.done_owed));
        chk("ready_b",  32'(rdy_b),          32'(m_ready(mb, en_b)));
        chk("onehot_b", 32'($countones(y_b) <= 1), 32'd1);
    endtask

    // Inputs are set at posedge+1; outputs compared at posedge+4; model advances on the edge.
    task automatic cycle();
        #3;
        check_all();
        @(posedge clk);
        m_step(ma, en_a, vld_a, int'(sel_a), OUT_A, HOLD_A, "a");
        m_step(mb, en_b, vld_b, int'(sel_b), OUT_B, HOLD_B, "b");
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b1; vld_a = 1'b0; sel_a = '0;
        en_b = 1'b1; vld_b = 1'b0; sel_b = '0;
        ma = m_reset();
        mb = m_reset();

        #2;
        chk("rst_y_a",     32'(y_a),    32'd0);
        chk("rst_busy_a",  32'(busy_a), 32'd0);
        chk("rst_ready_a", 32'(rdy_a),  32'd0);
        chk("rst_done_b",  32'(done_b), 32'd0);
        chk("rst_err_b",   32'(err_b),  32'd0);
        chk("rst_ready_b", 32'(rdy_b),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Sweep every select on the 8-way instance, one accept every 3 cycles.
        for (int s = 0; s < 8; s++) begin
            vld_a = 1'b1; sel_a = 3'(s);
            cycle();
            vld_a = 1'b0;
            repeat (2) cycle();
        end

        // Hold window of 4 with en dropped for 2 cycles in the middle.
        vld_b = 1'b1; sel_b = 3'd5;
        cycle();
        vld_b = 1'b0;
        repeat (2) cycle();
        en_b = 1'b0;
        repeat (2) cycle();
        en_b = 1'b1;
        repeat (5) cycle();

        // Out-of-range selects on the 6-way instance.
        vld_b = 1'b1; sel_b = 3'd6;
        cycle();
        sel_b = 3'd7;
        cycle();
        vld_b = 1'b0;
        repeat (2) cycle();

        // Pre-emption attempt in the second ACTIVE cycle.
        vld_b = 1'b1; sel_b = 3'd2;
        cycle();
        vld_b = 1'b0;
        cycle();
        vld_b = 1'b1; sel_b = 3'd4;
        cycle();
        vld_b = 1'b0;
        repeat (7) cycle();

        // Asynchronous reset in the middle of a hold window.
        vld_b = 1'b1; sel_b = 3'd5;
        cycle();
        vld_b = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_y_b",     32'(y_b),    32'd0);
        chk("midrst_busy_b",  32'(busy_b), 32'd0);
        chk("midrst_ready_b", 32'(rdy_b),  32'd0);
        ma = m_reset();
        mb = m_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle();

        // Continuous valid with a changing select.
        vld_a = 1'b1; vld_b = 1'b1;
        repeat (30) begin
            sel_a = 3'($urandom_range(0, 7));
            sel_b = 3'($urandom_range(0, 7));
            cycle();
        end

        // Fully random traffic including enable gaps.
        repeat (400) begin
            en_a  = ($urandom_range(0, 7) != 0);
            en_b  = ($urandom_range(0, 7) != 0);
            vld_a = $urandom_range(0, 1) == 1;
            vld_b = $urandom_range(0, 1) == 1;
            sel_a = 3'($urandom_range(0, 7));
            sel_b = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
